// File: rtl/ht_pkg.sv
// Shared types for the Hough-transform list sequencer.
// Op and FSM state encodings plus default bus widths.
package ht_pkg;

  localparam int DEF_RHO_W  = 10;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_NODE_W = 32;

  typedef enum logic [1:0] {
    OP_APPEND,
    OP_SEARCH,
    OP_SHOW
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

endpackage

// File: rtl/ht_list_sequencer_if.sv
// Command/response bus between the sequencer and the HTLinkList.
// The sequencer is the only master of the command pins.
interface ht_list_sequencer_if #(
  parameter int RHO_W  = ht_pkg::DEF_RHO_W,
  parameter int ADDR_W = ht_pkg::DEF_ADDR_W,
  parameter int NODE_W = ht_pkg::DEF_NODE_W
);
  logic              list_append;
  logic              list_search;
  logic              list_show;
  logic [RHO_W-1:0]  list_rho;
  logic [ADDR_W-1:0] list_addr;
  logic              list_done;
  logic              list_found;
  logic [NODE_W-1:0] list_node;

  modport master (
    output list_append, list_search, list_show,
    output list_rho, list_addr,
    input  list_done, list_found, list_node
  );

  modport slave (
    input  list_append, list_search, list_show,
    input  list_rho, list_addr,
    output list_done, list_found, list_node
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after last winner.
// Pointer moves only when the caller confirms the grant with advance.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;
  logic [PW-1:0] idx;
  logic          hit;

  always_comb begin
    grant = '0;
    ptr_n = ptr;
    idx   = '0;
    hit   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        ptr_n      = PW'((int'(idx) + 1) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance) ptr <= ptr_n;
  end
endmodule

// File: rtl/ht_list_sequencer.sv
// HTLinkList sequencer: arbitrates votes, host searches and dump sweeps
// into single list commands with a done watchdog.
module ht_list_sequencer
  import ht_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int RHO_W   = DEF_RHO_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NODE_W  = DEF_NODE_W,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       vote_valid,
  input  logic [N_REQ*RHO_W-1:0] vote_rho,
  output logic [N_REQ-1:0]       vote_ready,
  input  logic                   srch_valid,
  input  logic [RHO_W-1:0]       srch_rho,
  output logic                   srch_ready,
  input  logic                   dump_start,
  input  logic [ADDR_W-1:0]      dump_cnt,
  ht_list_sequencer_if.master    lst,
  output logic                   srch_rsp_valid,
  output logic                   srch_rsp_found,
  output logic                   dump_valid,
  output logic [ADDR_W-1:0]      dump_addr,
  output logic [NODE_W-1:0]      dump_node,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e            state, state_n;
  op_e               op_q;
  logic [RHO_W-1:0]  rho_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] pend_cnt;
  logic              pend;
  logic [WD_W-1:0]   wd;

  logic [N_REQ-1:0]  grant;
  logic [RHO_W-1:0]  win_rho;
  logic [ADDR_W:0]   addr_nx;
  logic idle_ok, dump_go, dump_skip, srch_go, vote_go;
  logic done_ok, tmo, more;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (vote_valid),
    .advance (vote_go),
    .grant   (grant)
  );

  always_comb begin
    win_rho = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) win_rho |= vote_rho[i*RHO_W +: RHO_W];
  end

  // Grants are masked during rst so nothing claims to be consumed.
  always_comb begin
    idle_ok    = (state == S_IDLE) && !rst;
    dump_go    = idle_ok && pend && (pend_cnt != '0);
    dump_skip  = idle_ok && pend && (pend_cnt == '0);
    srch_go    = idle_ok && !pend && srch_valid;
    vote_go    = idle_ok && !pend && !srch_valid
               && (vote_valid != '0);
    vote_ready = vote_go ? grant : '0;
    srch_ready = srch_go;
    done_ok    = (state == S_WAIT) && lst.list_done;
    tmo        = (state == S_WAIT) && !lst.list_done
               && (wd == WD_W'(TIMEOUT - 1));
    addr_nx    = {1'b0, addr_q} + (ADDR_W+1)'(1);
    more       = (op_q == OP_SHOW) && (addr_nx < {1'b0, cnt_q});
    state_n    = state;
    unique case (state)
      S_IDLE:  if (dump_go || srch_go || vote_go) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (done_ok) state_n = more ? S_ISSUE : S_IDLE;
        else if (tmo) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q           <= OP_APPEND;
      rho_q          <= '0;
      addr_q         <= '0;
      cnt_q          <= '0;
      pend           <= 1'b0;
      pend_cnt       <= '0;
      wd             <= '0;
      srch_rsp_valid <= 1'b0;
      srch_rsp_found <= 1'b0;
      dump_valid     <= 1'b0;
      dump_addr      <= '0;
      dump_node      <= '0;
      timeout_err    <= 1'b0;
    end else begin
      srch_rsp_valid <= 1'b0;
      dump_valid     <= 1'b0;
      wd <= (state == S_WAIT) ? wd + WD_W'(1) : '0;
      if (dump_go || dump_skip) begin
        pend <= 1'b0;
      end else if (dump_start && !pend) begin
        pend     <= 1'b1;
        pend_cnt <= dump_cnt;
      end
      unique case (1'b1)
        dump_go: begin
          op_q   <= OP_SHOW;
          rho_q  <= '0;
          addr_q <= '0;
          cnt_q  <= pend_cnt;
        end
        srch_go: begin
          op_q   <= OP_SEARCH;
          rho_q  <= srch_rho;
          addr_q <= '0;
        end
        vote_go: begin
          op_q   <= OP_APPEND;
          rho_q  <= win_rho;
          addr_q <= '0;
        end
        default: ;
      endcase
      if (done_ok) begin
        if (op_q == OP_SEARCH) begin
          srch_rsp_valid <= 1'b1;
          srch_rsp_found <= lst.list_found;
        end
        if (op_q == OP_SHOW) begin
          dump_valid <= 1'b1;
          dump_addr  <= addr_q;
          dump_node  <= lst.list_node;
          if (more) addr_q <= addr_nx[ADDR_W-1:0];
        end
      end else if (tmo) begin
        timeout_err <= 1'b1;
        if (op_q == OP_SEARCH) begin
          srch_rsp_valid <= 1'b1;
          srch_rsp_found <= 1'b0;
        end
      end
    end
  end

  assign lst.list_append = (state == S_ISSUE) && (op_q == OP_APPEND);
  assign lst.list_search = (state == S_ISSUE) && (op_q == OP_SEARCH);
  assign lst.list_show   = (state == S_ISSUE) && (op_q == OP_SHOW);
  assign lst.list_rho    = rho_q;
  assign lst.list_addr   = addr_q;
  assign busy            = (state != S_IDLE) || pend;
endmodule

// File: tb/tb_ht_list_sequencer.sv
// Bench for ht_list_sequencer: behavioural list stub, directed
// corner cases, an arbitration vector table and a random run.
module tb_ht_list_sequencer;
  localparam int N_REQ   = 4;
  localparam int RHO_W   = 10;
  localparam int ADDR_W  = 12;
  localparam int NODE_W  = 32;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]       vote_valid;
  logic [N_REQ*RHO_W-1:0] vote_rho;
  logic [N_REQ-1:0]       vote_ready;
  logic                   srch_valid;
  logic [RHO_W-1:0]       srch_rho;
  logic                   srch_ready;
  logic                   dump_start;
  logic [ADDR_W-1:0]      dump_cnt;
  logic                   srch_rsp_valid, srch_rsp_found;
  logic                   dump_valid;
  logic [ADDR_W-1:0]      dump_addr;
  logic [NODE_W-1:0]      dump_node;
  logic                   busy, timeout_err;

  ht_list_sequencer_if #(
    .RHO_W(RHO_W), .ADDR_W(ADDR_W), .NODE_W(NODE_W)
  ) lif ();

  ht_list_sequencer #(
    .N_REQ(N_REQ), .RHO_W(RHO_W), .ADDR_W(ADDR_W),
    .NODE_W(NODE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .vote_valid(vote_valid), .vote_rho(vote_rho),
    .vote_ready(vote_ready),
    .srch_valid(srch_valid), .srch_rho(srch_rho),
    .srch_ready(srch_ready),
    .dump_start(dump_start), .dump_cnt(dump_cnt),
    .lst(lif),
    .srch_rsp_valid(srch_rsp_valid),
    .srch_rsp_found(srch_rsp_found),
    .dump_valid(dump_valid), .dump_addr(dump_addr),
    .dump_node(dump_node),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural list: remembers appended rhos, fixed node words.
  int          stub_lat = 1;
  bit          stub_on = 1'b1;
  int          pend_done = 0;
  bit          list_set [1024];
  logic [31:0] node_mem [16];
  logic        s_found;
  logic [31:0] s_node;
  logic        stub_rs;

  always @(posedge clk) begin
    stub_rs = rst;
    #1;
    lif.list_done = 1'b0;
    if (stub_rs) begin
      pend_done      = 0;
      lif.list_found = 1'b0;
      lif.list_node  = '0;
      foreach (list_set[i]) list_set[i] = 1'b0;
    end else begin
      if (pend_done > 0) begin
        pend_done--;
        if (pend_done == 0) begin
          lif.list_done  = 1'b1;
          lif.list_found = s_found;
          lif.list_node  = s_node;
        end
      end
      if (lif.list_append || lif.list_search || lif.list_show) begin
        if (lif.list_append) list_set[lif.list_rho] = 1'b1;
        s_found = lif.list_search && list_set[lif.list_rho];
        s_node  = node_mem[lif.list_addr[3:0]];
        if (stub_on) pend_done = stub_lat;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    vote_valid = '0; vote_rho = '0;
    srch_valid = 1'b0; srch_rho = '0;
    dump_start = 1'b0; dump_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, c < 200, 1);
  endtask

  task automatic do_vote(input int lane, input logic [9:0] rho,
                         input string name);
    int c;
    @(posedge clk); #1;
    vote_valid = '0;
    vote_valid[lane] = 1'b1;
    vote_rho = '0;
    vote_rho[lane*RHO_W +: RHO_W] = rho;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (vote_ready[lane]) break;
    end
    chk(name, c < 50, 1);
    @(posedge clk); #1;
    vote_valid = '0;
  endtask

  task automatic do_search(input logic [9:0] rho, input string name,
                           input logic exp_found);
    int c;
    int pulses;
    logic fnd;
    pulses = 0;
    fnd = 1'bx;
    @(posedge clk); #1;
    srch_valid = 1'b1;
    srch_rho = rho;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (srch_ready) break;
    end
    chk({name, "_acc"}, c < 50, 1);
    @(posedge clk); #1;
    srch_valid = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (srch_rsp_valid) begin
        pulses++;
        fnd = srch_rsp_found;
      end
    end
    chk({name, "_pulses"}, pulses, 1);
    chk({name, "_found"}, fnd, exp_found);
  endtask

  typedef struct {
    logic [3:0] vv;
    logic       sv;
    logic [3:0] vr;
    logic       sr;
    logic [9:0] rho;
  } vec_t;

  vec_t        tbl [11];
  int          rr_exp [5] = '{0, 1, 2, 3, 0};
  int          got [$];
  int          shows, dumps, done_cyc, show_cyc, cyc, tick;
  int          last_g, act, exp_l, n_grant;
  logic [9:0]  r;
  logic [9:0]  q_app [$];
  logic [9:0]  q_srch [$];
  bit          fire_v [N_REQ];
  bit          fire_s;
  bit          model_set [1024];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    foreach (node_mem[i]) node_mem[i] = $urandom;
    tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 10'd100};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 10'd100};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 10'd500};
    tbl[3]  = '{4'b1111, 1'b0, 4'b0010, 1'b0, 10'd101};
    tbl[4]  = '{4'b1001, 1'b0, 4'b1000, 1'b0, 10'd103};
    tbl[5]  = '{4'b1001, 1'b0, 4'b0001, 1'b0, 10'd100};
    tbl[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 10'd102};
    tbl[7]  = '{4'b0110, 1'b0, 4'b0010, 1'b0, 10'd101};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 10'd500};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 10'd0};
    tbl[10] = '{4'b1100, 1'b0, 4'b0100, 1'b0, 10'd102};

    do_reset();
    @(negedge clk);
    chk("rst_ctl", {vote_ready, srch_ready, lif.list_append,
        lif.list_search, lif.list_show, srch_rsp_valid,
        srch_rsp_found, dump_valid, busy, timeout_err}, 0);
    chk("rst_bus", {lif.list_rho, lif.list_addr}, 0);
    chk("rst_dump", {dump_addr, dump_node}, 0);

    // All lanes held: grants rotate starting at lane 0.
    @(posedge clk); #1;
    vote_valid = 4'hF;
    vote_rho = {10'd13, 10'd12, 10'd11, 10'd10};
    for (int c = 0; c < 60 && got.size() < 5; c++) begin
      @(negedge clk);
      if (lif.list_append && got.size() > 0)
        chk("rr_rho", lif.list_rho, 10 + got[$]);
      if (vote_ready != 0) begin
        chk("rr_onehot", $onehot(vote_ready), 1);
        for (int l = 0; l < N_REQ; l++)
          if (vote_ready[l]) got.push_back(l);
      end
    end
    @(posedge clk); #1;
    vote_valid = '0;
    chk("rr_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("rr_order", got[i], rr_exp[i]);
    wait_idle("rr_idle");

    // Single vote timing.
    stub_lat = 1;
    @(posedge clk); #1;
    vote_valid = 4'b0001;
    vote_rho = 40'd123;
    @(negedge clk);
    chk("t1_grant", vote_ready, 4'b0001);
    @(posedge clk); #1;
    vote_valid = '0;
    @(negedge clk);
    chk("t1_op", {lif.list_append, lif.list_search, lif.list_show}, 3'b100);
    chk("t1_rho", lif.list_rho, 123);
    @(negedge clk);
    chk("t1_done", lif.list_done, 1);
    chk("t1_rho_hold", lif.list_rho, 123);
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // Search hit and miss.
    do_vote(2, 10'd123, "t3_v1");
    wait_idle("t3_i1");
    do_vote(1, 10'd321, "t3_v2");
    wait_idle("t3_i2");
    do_search(10'd321, "t3_hit", 1'b1);
    do_search(10'd789, "t3_miss", 1'b0);

    // Dump sweep of 10 addresses.
    stub_lat = 2;
    shows = 0;
    dumps = 0;
    @(posedge clk); #1;
    dump_start = 1'b1;
    dump_cnt = 12'd10;
    @(posedge clk); #1;
    dump_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (lif.list_show) shows++;
      if (dump_valid) begin
        chk("dump_addr", dump_addr, dumps);
        chk("dump_node", dump_node, node_mem[dumps % 16]);
        dumps++;
      end
      if (!busy) break;
    end
    chk("dump_shows", shows, 10);
    chk("dump_count", dumps, 10);

    // dump_cnt = 0 is a no-op.
    shows = 0;
    dumps = 0;
    @(posedge clk); #1;
    dump_start = 1'b1;
    dump_cnt = '0;
    @(posedge clk); #1;
    dump_start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (lif.list_show) shows++;
      if (dump_valid) dumps++;
    end
    chk("dump0_none", {shows[7:0], dumps[7:0]}, 0);
    chk("dump0_idle", busy, 0);

    // dump_start during an append waits for that append.
    stub_lat = 5;
    shows = 0;
    done_cyc = -1;
    show_cyc = -1;
    do_vote(3, 10'd7, "defer_v");
    dump_start = 1'b1;
    dump_cnt = 12'd2;
    @(posedge clk); #1;
    dump_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (lif.list_done && done_cyc < 0) done_cyc = c;
      if (lif.list_show) begin
        if (show_cyc < 0) show_cyc = c;
        shows++;
      end
      if (!busy && shows > 0) break;
    end
    chk("defer_gap", show_cyc - done_cyc, 2);
    chk("defer_shows", shows, 2);
    stub_lat = 1;

    // Watchdog: list never answers.
    stub_on = 1'b0;
    @(posedge clk); #1;
    vote_valid = 4'b0001;
    vote_rho = 40'd55;
    @(negedge clk);
    chk("to_grant", vote_ready, 4'b0001);
    @(posedge clk); #1;
    vote_valid = '0;
    @(negedge clk);
    chk("to_issue", lif.list_append, 1);
    repeat (TIMEOUT) @(negedge clk);
    chk("to_last_wait", {busy, timeout_err}, 2'b10);
    @(negedge clk);
    chk("to_expired", {busy, timeout_err}, 2'b01);
    do_search(10'd77, "to_srch", 1'b0);
    stub_on = 1'b1;
    do_vote(1, 10'd200, "to_next_vote");
    wait_idle("to_next_idle");

    // Reset in the middle of WAIT.
    stub_on = 1'b0;
    do_vote(2, 10'd99, "rw_v");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_ctl", {vote_ready, srch_ready, lif.list_append,
        lif.list_search, lif.list_show, srch_rsp_valid,
        srch_rsp_found, dump_valid, busy, timeout_err}, 0);
    chk("rw_bus", {lif.list_rho, lif.list_addr}, 0);
    chk("rw_dump", {dump_addr, dump_node}, 0);
    stub_on = 1'b1;

    // Arbitration vector table, pointer starts at lane 0.
    do_reset();
    vote_rho = {10'd103, 10'd102, 10'd101, 10'd100};
    srch_rho = 10'd500;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      vote_valid = tbl[i].vv;
      srch_valid = tbl[i].sv;
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", i), {vote_ready, srch_ready},
          {tbl[i].vr, tbl[i].sr});
      @(posedge clk); #1;
      vote_valid = '0;
      srch_valid = 1'b0;
      @(negedge clk);
      if (tbl[i].vr != 0 || tbl[i].sr) begin
        chk($sformatf("tbl%0d_op", i),
            {lif.list_append, lif.list_search, lif.list_show},
            {tbl[i].vr != 0, tbl[i].sr, 1'b0});
        chk($sformatf("tbl%0d_rho", i), lif.list_rho, tbl[i].rho);
        wait_idle($sformatf("tbl%0d_idle", i));
      end else begin
        chk($sformatf("tbl%0d_quiet", i), busy, 0);
      end
    end

    // Random votes and searches against a transaction model.
    do_reset();
    foreach (model_set[i]) model_set[i] = 1'b0;
    last_g = N_REQ - 1;
    n_grant = 0;
    for (tick = 0; tick < 1600; tick++) begin
      @(negedge clk);
      foreach (fire_v[l]) fire_v[l] = 1'b0;
      fire_s = 1'b0;
      if (srch_rsp_valid) begin
        if (q_srch.size() == 0) chk("rnd_rsp_extra", 1, 0);
        else begin
          r = q_srch.pop_front();
          chk("rnd_found", srch_rsp_found, model_set[r]);
        end
      end
      if (lif.list_append) begin
        if (q_app.size() == 0) chk("rnd_app_extra", 1, 0);
        else chk("rnd_app_rho", lif.list_rho, q_app.pop_front());
      end
      if (srch_ready) begin
        q_srch.push_back(srch_rho);
        fire_s = 1'b1;
      end
      if (vote_ready != 0) begin
        exp_l = -1;
        for (int k = 1; k <= N_REQ; k++)
          if (exp_l < 0 && vote_valid[(last_g + k) % N_REQ])
            exp_l = (last_g + k) % N_REQ;
        act = -1;
        for (int l = 0; l < N_REQ; l++) if (vote_ready[l]) act = l;
        chk("rnd_onehot", $onehot(vote_ready), 1);
        chk("rnd_rr", act, exp_l);
        chk("rnd_srch_first", srch_valid, 0);
        if (act >= 0) begin
          last_g = act;
          fire_v[act] = 1'b1;
          r = vote_rho[act*RHO_W +: RHO_W];
          q_app.push_back(r);
          model_set[r] = 1'b1;
          n_grant++;
        end
      end
      @(posedge clk); #1;
      stub_lat = $urandom_range(1, 4);
      for (int l = 0; l < N_REQ; l++) begin
        if (fire_v[l] || !vote_valid[l]) begin
          vote_valid[l] = (tick < 1200) && ($urandom_range(0, 3) == 0);
          vote_rho[l*RHO_W +: RHO_W] = 10'($urandom_range(0, 31));
        end
      end
      if (fire_s || !srch_valid) begin
        srch_valid = (tick < 1200) && ($urandom_range(0, 7) == 0);
        srch_rho = 10'($urandom_range(0, 40));
      end
    end
    chk("rnd_app_drained", q_app.size(), 0);
    chk("rnd_srch_drained", q_srch.size(), 0);
    chk("rnd_votes_done", vote_valid, 0);
    chk("rnd_activity", n_grant > 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
